// File: rtl/qracc_ctrl.sv
// qracc_ctrl: command sequencer for a ternary-activation compute-in-memory SRAM macro.
// Ports: cmd_* request in, rsp_* response out, err flag, registered macro controls, SA_OUT/ADC_OUT in.
module qracc_ctrl #(
  parameter int numRows      = 128,
  parameter int numCols      = 8,
  parameter int numAdcBits   = 4,
  parameter int settleCycles = 2,
  localparam int compCount   = 2**numAdcBits - 1,
  localparam int RW          = (numRows > 1) ? $clog2(numRows) : 1
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [1:0]                       cmd_op,
  input  logic [RW-1:0]                    cmd_row,
  input  logic [numCols-1:0]               cmd_wdata,
  input  logic [numRows-1:0]               cmd_act_pos,
  input  logic [numRows-1:0]               cmd_act_neg,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [numCols-1:0]               rsp_rdata,
  output logic [numCols*numAdcBits-1:0]    rsp_mac,
  output logic                             err,
  output logic [numRows-1:0]               WL,
  output logic                             PCH,
  output logic                             WRITE,
  output logic [numCols-1:0]               WR_DATA,
  output logic [numCols-1:0]               CSEL,
  output logic                             SAEN,
  output logic [numRows-1:0]               VDR_SEL,
  output logic [numRows-1:0]               VDR_SELB,
  output logic [numRows-1:0]               VSS_SEL,
  output logic [numRows-1:0]               VSS_SELB,
  output logic [numRows-1:0]               VRST_SEL,
  output logic [numRows-1:0]               VRST_SELB,
  output logic                             NF,
  output logic                             NFB,
  output logic                             M2A,
  output logic                             M2AB,
  output logic                             R2A,
  output logic                             R2AB,
  input  logic [numCols-1:0]               SA_OUT,
  input  logic [compCount*numCols-1:0]     ADC_OUT
);

  typedef enum logic [2:0] {
    IDLE, WR, RD, MRST, MEVAL, RESP
  } state_t;

  localparam logic [numAdcBits:0] HALF =
    (numAdcBits+1)'(2**(numAdcBits-1));

  state_t                          r_state;
  logic [3:0]                      r_cnt;
  logic [numRows-1:0]              r_pos;
  logic [numRows-1:0]              r_neg;

  state_t                          w_nstate;
  logic                            w_accept;
  logic                            w_last;
  logic                            w_eval;
  logic [numRows-1:0]              w_row1h;
  logic [numRows-1:0]              w_wl;
  logic                            w_pch;
  logic                            w_write;
  logic [numCols-1:0]              w_wrdata;
  logic [numCols-1:0]              w_csel;
  logic                            w_saen;
  logic [numRows-1:0]              w_vdr;
  logic [numRows-1:0]              w_vss;
  logic [numRows-1:0]              w_vrst;
  logic                            w_m2a;
  logic                            w_r2a;
  logic [numAdcBits:0]             w_pc;
  logic [numAdcBits:0]             w_diff;
  logic [numCols*numAdcBits-1:0]   w_mac;

  assign w_accept = cmd_valid && cmd_ready;
  assign w_last   = (r_cnt == 4'(settleCycles-1));
  // evaluation drive holds from MRST exit through every MEVAL cycle but the last
  assign w_eval   = (r_state == MRST) ||
                    ((r_state == MEVAL) && !w_last);

  // out-of-range rows select no wordline
  always_comb begin
    w_row1h = '0;
    if (int'(cmd_row) < numRows) w_row1h[cmd_row] = 1'b1;
  end

  always_comb begin
    w_nstate = r_state;
    w_wl     = '0;
    w_pch    = 1'b0;
    w_write  = 1'b0;
    w_wrdata = '0;
    w_csel   = '0;
    w_saen   = 1'b0;
    w_vdr    = '0;
    w_vss    = '0;
    w_vrst   = '1;
    w_m2a    = 1'b0;
    w_r2a    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          unique case (cmd_op)
            2'b00: begin
              w_nstate = WR;
              w_wl     = w_row1h;
              w_pch    = 1'b1;
              w_write  = 1'b1;
              w_wrdata = cmd_wdata;
              w_csel   = '1;
            end
            2'b01: begin
              w_nstate = RD;
              w_wl     = w_row1h;
              w_pch    = 1'b1;
              w_saen   = 1'b1;
            end
            2'b10: begin
              w_nstate = MRST;
              w_r2a    = 1'b1;
            end
            default: w_nstate = IDLE;
          endcase
        end
      end
      WR:    w_nstate = IDLE;
      RD:    w_nstate = RESP;
      MRST:  w_nstate = MEVAL;
      MEVAL: if (w_last) w_nstate = RESP;
      RESP:  if (rsp_ready) w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
    if (w_eval) begin
      w_vdr  = r_pos & ~r_neg;
      w_vss  = r_neg & ~r_pos;
      w_vrst = ~(r_pos ^ r_neg);
      w_m2a  = 1'b1;
    end
  end

  // thermometer code -> signed offset; popcount makes bubbles harmless
  always_comb begin
    w_mac  = '0;
    w_pc   = '0;
    w_diff = '0;
    for (int j = 0; j < numCols; j++) begin
      w_pc = '0;
      for (int k = 0; k < compCount; k++)
        w_pc = w_pc + {{numAdcBits{1'b0}}, ADC_OUT[j*compCount+k]};
      w_diff = w_pc - HALF;
      w_mac[j*numAdcBits +: numAdcBits] = w_diff[numAdcBits-1:0];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pos     <= '0;
      r_neg     <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_mac   <= '0;
      err       <= 1'b0;
      WL        <= '0;
      PCH       <= 1'b0;
      WRITE     <= 1'b0;
      WR_DATA   <= '0;
      CSEL      <= '0;
      SAEN      <= 1'b0;
      VDR_SEL   <= '0;
      VDR_SELB  <= '1;
      VSS_SEL   <= '0;
      VSS_SELB  <= '1;
      VRST_SEL  <= '1;
      VRST_SELB <= '0;
      NF        <= 1'b0;
      NFB       <= 1'b1;
      M2A       <= 1'b0;
      M2AB      <= 1'b1;
      R2A       <= 1'b0;
      R2AB      <= 1'b1;
    end else begin
      r_state   <= w_nstate;
      cmd_ready <= (w_nstate == IDLE);
      rsp_valid <= (w_nstate == RESP);
      WL        <= w_wl;
      PCH       <= w_pch;
      WRITE     <= w_write;
      WR_DATA   <= w_wrdata;
      CSEL      <= w_csel;
      SAEN      <= w_saen;
      VDR_SEL   <= w_vdr;
      VDR_SELB  <= ~w_vdr;
      VSS_SEL   <= w_vss;
      VSS_SELB  <= ~w_vss;
      VRST_SEL  <= w_vrst;
      VRST_SELB <= ~w_vrst;
      NF        <= 1'b0;
      NFB       <= 1'b1;
      M2A       <= w_m2a;
      M2AB      <= ~w_m2a;
      R2A       <= w_r2a;
      R2AB      <= ~w_r2a;
      if (w_accept) begin
        r_pos <= cmd_act_pos;
        r_neg <= cmd_act_neg;
        if (cmd_op == 2'b11) err <= 1'b1;
      end
      if (r_state == MRST) r_cnt <= '0;
      else if (r_state == MEVAL) r_cnt <= r_cnt + 4'd1;
      if (r_state == RD) begin
        rsp_rdata <= SA_OUT;
        rsp_mac   <= '0;
      end
      if ((r_state == MEVAL) && w_last) begin
        rsp_mac   <= w_mac;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_qracc_ctrl.sv
// tb_qracc_ctrl: scoreboard bench for qracc_ctrl with default parameters.
// Stimulus drives and samples on the falling clock edge.
module tb_qracc_ctrl;

  localparam int NR = 128;
  localparam int NC = 8;
  localparam int NB = 4;
  localparam int CC = 15;

  typedef struct {
    logic [NC-1:0]    rdata;
    logic [NC*NB-1:0] mac;
    int               lat;
  } exp_t;

  logic              CLK = 1'b0;
  logic              RST;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [6:0]        cmd_row;
  logic [NC-1:0]     cmd_wdata;
  logic [NR-1:0]     cmd_act_pos;
  logic [NR-1:0]     cmd_act_neg;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [NC-1:0]     rsp_rdata;
  logic [NC*NB-1:0]  rsp_mac;
  logic              err;
  logic [NR-1:0]     WL;
  logic              PCH;
  logic              WRITE;
  logic [NC-1:0]     WR_DATA;
  logic [NC-1:0]     CSEL;
  logic              SAEN;
  logic [NR-1:0]     VDR_SEL;
  logic [NR-1:0]     VDR_SELB;
  logic [NR-1:0]     VSS_SEL;
  logic [NR-1:0]     VSS_SELB;
  logic [NR-1:0]     VRST_SEL;
  logic [NR-1:0]     VRST_SELB;
  logic              NF;
  logic              NFB;
  logic              M2A;
  logic              M2AB;
  logic              R2A;
  logic              R2AB;
  logic [NC-1:0]     SA_OUT;
  logic [CC*NC-1:0]  ADC_OUT;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  qracc_ctrl dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_row(cmd_row),
    .cmd_wdata(cmd_wdata),
    .cmd_act_pos(cmd_act_pos), .cmd_act_neg(cmd_act_neg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_mac(rsp_mac),
    .err(err), .WL(WL), .PCH(PCH), .WRITE(WRITE),
    .WR_DATA(WR_DATA), .CSEL(CSEL), .SAEN(SAEN),
    .VDR_SEL(VDR_SEL), .VDR_SELB(VDR_SELB),
    .VSS_SEL(VSS_SEL), .VSS_SELB(VSS_SELB),
    .VRST_SEL(VRST_SEL), .VRST_SELB(VRST_SELB),
    .NF(NF), .NFB(NFB), .M2A(M2A), .M2AB(M2AB),
    .R2A(R2A), .R2AB(R2AB),
    .SA_OUT(SA_OUT), .ADC_OUT(ADC_OUT)
  );

  function automatic logic [NC*NB-1:0] mac_model(input logic [CC*NC-1:0] adc);
    logic [NC*NB-1:0] m;
    int cnt;
    m = '0;
    for (int j = 0; j < NC; j++) begin
      cnt = $countones(adc[j*CC +: CC]);
      m[j*NB +: NB] = 4'(cnt - 8);
    end
    return m;
  endfunction

  function automatic logic [CC*NC-1:0] rand_adc();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[CC*NC-1:0];
  endfunction

  // returns at the falling edge of the cycle after the accept edge
  task automatic issue(input logic [1:0] op, input logic [6:0] row,
                       input logic [NC-1:0] wd,
                       input logic [NR-1:0] p, input logic [NR-1:0] n);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_row     = row;
    cmd_wdata   = wd;
    cmd_act_pos = p;
    cmd_act_neg = n;
    @(posedge CLK);
    @(negedge CLK);
    cmd_valid   = 1'b0;
  endtask

  // scoreboard consumer: wait for the response, pop, compare, hold, release
  task automatic drain(input int start, input int hold);
    exp_t e;
    int cyc;
    cyc = start;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      @(negedge CLK);
      cyc++;
    end
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, want 1", rsp_valid, cyc);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL sb_empty: response seen with no expected entry");
      return;
    end
    e = sb.pop_front();
    if (cyc !== e.lat) begin
      miscompares++;
      $display("FAIL rsp_latency: got %0d want %0d", cyc, e.lat);
    end
    vectors++;
    if (rsp_rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL rsp_rdata: got %h want %h", rsp_rdata, e.rdata);
    end
    vectors++;
    if (rsp_mac !== e.mac) begin
      miscompares++;
      $display("FAIL rsp_mac: got %h want %h", rsp_mac, e.mac);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_mac !== e.mac) begin
        miscompares++;
        $display("FAIL rsp_hold%0d: valid=%b rdata=%h mac=%h want 1 %h %h",
                 h, rsp_valid, rsp_rdata, rsp_mac, e.rdata, e.mac);
      end
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rsp_release: valid=%b ready=%b want 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    vectors++;
    if (rsp_valid !== 1'b0 || err !== 1'b0 || rsp_mac !== '0 || rsp_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_rsp: valid=%b err=%b mac=%h rdata=%h want 0 0 0 0",
               rsp_valid, err, rsp_mac, rsp_rdata);
    end
    vectors++;
    if (WL !== '0 || PCH !== 1'b0 || WRITE !== 1'b0 || SAEN !== 1'b0 ||
        WR_DATA !== '0 || CSEL !== '0) begin
      miscompares++;
      $display("FAIL reset_rw: WL=%h PCH=%b WRITE=%b SAEN=%b WD=%h CSEL=%h want zeros",
               WL, PCH, WRITE, SAEN, WR_DATA, CSEL);
    end
    vectors++;
    if (VRST_SEL !== '1 || VDR_SEL !== '0 || VSS_SEL !== '0 ||
        VRST_SELB !== '0 || VDR_SELB !== '1 || VSS_SELB !== '1) begin
      miscompares++;
      $display("FAIL reset_vsel: VRST=%h VDR=%h VSS=%h", VRST_SEL, VDR_SEL, VSS_SEL);
    end
    vectors++;
    if (M2A !== 1'b0 || R2A !== 1'b0 || NF !== 1'b0 ||
        M2AB !== 1'b1 || R2AB !== 1'b1 || NFB !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ctl: M2A=%b R2A=%b NF=%b M2AB=%b R2AB=%b NFB=%b want 000111",
               M2A, R2A, NF, M2AB, R2AB, NFB);
    end
    RST = 1'b0;
    @(negedge CLK);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    issue(2'b00, 7'd5, 8'hA5, '0, '0);
    vectors++;
    if (WL !== (NR'(1) << 5) || PCH !== 1'b1 || WRITE !== 1'b1 ||
        WR_DATA !== 8'hA5 || CSEL !== 8'hFF || SAEN !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_drive: WL=%h PCH=%b WRITE=%b WD=%h CSEL=%h SAEN=%b",
               WL, PCH, WRITE, WR_DATA, CSEL, SAEN);
    end
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_busy: cmd_ready=%b want 0", cmd_ready);
    end
    @(negedge CLK);
    vectors++;
    if (cmd_ready !== 1'b1 || WL !== '0 || WRITE !== 1'b0 ||
        PCH !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_done: ready=%b WL=%h WRITE=%b PCH=%b valid=%b want 1 0 0 0 0",
               cmd_ready, WL, WRITE, PCH, rsp_valid);
    end
  endtask

  task automatic test_read();
    exp_t e;
    SA_OUT = 8'hA5;
    e.rdata = 8'hA5;
    e.mac = '0;
    e.lat = 2;
    sb.push_back(e);
    issue(2'b01, 7'd5, 8'h00, '0, '0);
    vectors++;
    if (WL !== (NR'(1) << 5) || PCH !== 1'b1 || SAEN !== 1'b1 || WRITE !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_drive: WL=%h PCH=%b SAEN=%b WRITE=%b", WL, PCH, SAEN, WRITE);
    end
    drain(1, 3);
  endtask

  task automatic test_mac();
    exp_t e;
    ADC_OUT = {15'h4000, 15'h7FFE, 15'h0001, 15'h5555,
               15'h0F0F, 15'h00FF, 15'h0000, 15'h7FFF};
    e.rdata = '0;
    e.mac = mac_model(ADC_OUT);
    e.lat = 4;
    sb.push_back(e);
    issue(2'b10, 7'd0, 8'h00, '1, '0);
    drain(1, 0);
  endtask

  task automatic test_mac_drive();
    exp_t e;
    logic [NR-1:0] p;
    logic [NR-1:0] n;
    p = NR'(5);
    n = NR'(6);
    ADC_OUT = rand_adc();
    e.rdata = '0;
    e.mac = mac_model(ADC_OUT);
    e.lat = 4;
    sb.push_back(e);
    issue(2'b10, 7'd0, 8'h00, p, n);
    vectors++;
    if (VRST_SEL !== '1 || VDR_SEL !== '0 || VSS_SEL !== '0 ||
        R2A !== 1'b1 || M2A !== 1'b0 || R2AB !== 1'b0) begin
      miscompares++;
      $display("FAIL mrst_drive: VRST=%h VDR=%h VSS=%h R2A=%b M2A=%b R2AB=%b",
               VRST_SEL, VDR_SEL, VSS_SEL, R2A, M2A, R2AB);
    end
    @(negedge CLK);
    vectors++;
    if (VDR_SEL !== NR'(1) || VSS_SEL !== NR'(2) ||
        VRST_SEL !== ~NR'(3) || M2A !== 1'b1 || R2A !== 1'b0) begin
      miscompares++;
      $display("FAIL meval_drive: VDR=%h VSS=%h VRST=%h M2A=%b R2A=%b",
               VDR_SEL, VSS_SEL, VRST_SEL, M2A, R2A);
    end
    vectors++;
    if (VDR_SELB !== ~VDR_SEL || VSS_SELB !== ~VSS_SEL ||
        VRST_SELB !== ~VRST_SEL || M2AB !== ~M2A || R2AB !== ~R2A || NFB !== ~NF) begin
      miscompares++;
      $display("FAIL meval_comp: VDRB=%h VSSB=%h VRSTB=%h M2AB=%b", VDR_SELB,
               VSS_SELB, VRST_SELB, M2AB);
    end
    drain(2, 0);
  endtask

  task automatic test_illegal();
    issue(2'b11, 7'd9, 8'h00, '0, '0);
    vectors++;
    if (err !== 1'b1 || cmd_ready !== 1'b1 || WL !== '0 || WRITE !== 1'b0 ||
        R2A !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal: err=%b ready=%b WL=%h WRITE=%b R2A=%b valid=%b",
               err, cmd_ready, WL, WRITE, R2A, rsp_valid);
    end
    repeat (3) begin
      @(negedge CLK);
      vectors++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || err !== 1'b1) begin
        miscompares++;
        $display("FAIL illegal_idle: valid=%b ready=%b err=%b want 0 1 1",
                 rsp_valid, cmd_ready, err);
      end
    end
    issue(2'b00, 7'd3, 8'h3C, '0, '0);
    vectors++;
    if (WRITE !== 1'b1 || WL !== (NR'(1) << 3) || WR_DATA !== 8'h3C) begin
      miscompares++;
      $display("FAIL illegal_then_wr: WRITE=%b WL=%h WD=%h", WRITE, WL, WR_DATA);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    ADC_OUT = rand_adc();
    issue(2'b10, 7'd0, 8'h00, NR'(1), '0);
    @(negedge CLK);
    vectors++;
    if (M2A !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_meval: M2A=%b want 1", M2A);
    end
    #2 RST = 1'b1;
    #1;
    vectors++;
    if (M2A !== 1'b0 || M2AB !== 1'b1 || VRST_SEL !== '1 || VDR_SEL !== '0 ||
        rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: M2A=%b M2AB=%b VRST=%h VDR=%h valid=%b ready=%b err=%b",
               M2A, M2AB, VRST_SEL, VDR_SEL, rsp_valid, cmd_ready, err);
    end
    @(negedge CLK);
    RST = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      vectors++;
      if (rsp_valid !== 1'b0 || M2A !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_after: valid=%b M2A=%b want 0 0", rsp_valid, M2A);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [6:0] row;
    for (int i = 0; i < 4; i++) begin
      SA_OUT = 8'($urandom);
      row = 7'($urandom);
      e.rdata = SA_OUT;
      e.mac = '0;
      e.lat = 2;
      sb.push_back(e);
      issue(2'b01, row, 8'h00, '0, '0);
      vectors++;
      if (WL !== (NR'(1) << row)) begin
        miscompares++;
        $display("FAIL b2b_rd_wl%0d: got %h want bit %0d", i, WL, row);
      end
      drain(1, i);
      ADC_OUT = rand_adc();
      e.rdata = '0;
      e.mac = mac_model(ADC_OUT);
      e.lat = 4;
      sb.push_back(e);
      issue(2'b10, 7'd0, 8'h00, {4{$urandom}}, {4{$urandom}});
      drain(1, 0);
      issue(2'b00, 7'd127, 8'($urandom), '0, '0);
      vectors++;
      if (WL !== (NR'(1) << 127) || WRITE !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_wr_top%0d: WL=%h WRITE=%b", i, WL, WRITE);
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    RST = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_row = '0;
    cmd_wdata = '0;
    cmd_act_pos = '0;
    cmd_act_neg = '0;
    rsp_ready = 1'b0;
    SA_OUT = '0;
    ADC_OUT = '0;
    test_reset();
    test_write();
    test_read();
    test_mac();
    test_mac_drive();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: %0d entries remain", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/qracc_ctrl.md
QRACC_CTRL -- requirements
Module: qracc_ctrl

Interface
REQ-001 Parameter numRows, default 128, number of SRAM rows / activation inputs.
REQ-002 Parameter numCols, default 8, number of columns / MAC outputs.
REQ-003 Parameter numAdcBits, default 4, ADC result width; compCount = 2**numAdcBits-1.
REQ-004 Parameter settleCycles, default 2 (legal 1..15), evaluation cycles per MAC.
REQ-005 One clock; reset is asynchronous and active-high. CLK  input  1  clock, all logic on rising edge.
REQ-006 RST  input  1  asynchronous active-high reset.
REQ-007 cmd_valid  input  1; cmd_ready  output  1  command handshake.
REQ-008 cmd_op  input  2  00 write, 01 read, 10 MAC, 11 illegal.
REQ-009 cmd_row  input  $clog2(numRows)  row address (write/read).
REQ-010 cmd_wdata  input  numCols  write data.
REQ-011 cmd_act_pos, cmd_act_neg  input  numRows each  ternary activation per row (+1, -1, both/neither = 0).
REQ-012 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-013 rsp_rdata  output  numCols  read data; rsp_mac  output  numCols*numAdcBits  signed per-column MAC results, column j at [j*numAdcBits +: numAdcBits].
REQ-014 err  output  1  sticky illegal-op flag.
REQ-015 Macro side outputs: WL[numRows], PCH, WRITE, WR_DATA[numCols], CSEL[numCols], SAEN, VDR_SEL/VDR_SELB, VSS_SEL/VSS_SELB, VRST_SEL/VRST_SELB [numRows each], NF, NFB, M2A, M2AB, R2A, R2AB; inputs SA_OUT[numCols], ADC_OUT[compCount*numCols].

Function
REQ-016 All macro-side outputs SHALL be registered; every *B signal SHALL equal the bitwise complement of its partner every cycle.
REQ-017 FSM states SHALL be IDLE, WR, RD, MRST, MEVAL, RESP.
REQ-018 cmd_ready SHALL be 1 only in IDLE; command accepted on cmd_valid && cmd_ready.
REQ-019 Write: IDLE->WR for exactly one cycle with WL one-hot at cmd_row, PCH=1, WRITE=1, WR_DATA=cmd_wdata, CSEL all ones; then IDLE; no response.
REQ-020 Read: IDLE->RD for one cycle with WL one-hot, PCH=1, SAEN=1, WRITE=0; SA_OUT captured into rsp_rdata at end of RD; then RESP.
REQ-021 MAC: IDLE->MRST one cycle with VRST_SEL all ones, VDR_SEL/VSS_SEL zero, R2A=1; then MEVAL for settleCycles cycles.
REQ-022 In MEVAL per row i: VDR_SEL[i]=pos&~neg, VSS_SEL[i]=neg&~pos, VRST_SEL[i]=~(pos^neg); M2A=1; activations latched at accept.
REQ-023 On last MEVAL cycle ADC_OUT SHALL be captured; per column result = popcount(column's compCount bits) - 2**(numAdcBits-1), range -8..7 for defaults, bubble codes decoded by popcount only; then RESP.
REQ-024 NF SHALL be 0 (NFB=1) in all states.
REQ-025 RESP: rsp_valid=1, rsp_rdata/rsp_mac stable until rsp_valid && rsp_ready, then IDLE; a read zeroes rsp_mac, a MAC zeroes rsp_rdata.
REQ-026 Latency from accept edge: read rsp_valid at cycle 2; MAC rsp_valid at cycle 2+settleCycles; write cmd_ready high again at cycle 2.
REQ-027 Illegal op 11: accepted, no macro activity, no response, err set until reset, stay IDLE.
REQ-028 Outside WR/RD: WL zero, PCH/WRITE/SAEN zero; outside MRST/MEVAL: VRST_SEL all ones, VDR/VSS_SEL zero, M2A=R2A=0.
REQ-029 cmd_row >= numRows SHALL drive WL all zero (no row touched), response still produced for read.

Reset
REQ-030 While RST=1: state IDLE, cmd_ready=1 after deassert, rsp_valid=0, err=0, rsp data zero, WL/PCH/WRITE/SAEN/WR_DATA/CSEL zero, VRST_SEL all ones, VDR_SEL/VSS_SEL zero, M2A/R2A/NF zero, all *B complements.
REQ-031 RST mid-operation SHALL abort immediately with no response and no partial write completed after assertion.

Verification
REQ-032 Write row 5 data 8'hA5 -> one cycle WL=1<<5, PCH=WRITE=1, WR_DATA=A5; cmd_ready low exactly one cycle.
REQ-033 Read row 5 with SA_OUT=A5 -> rsp_valid at cycle 2, rsp_rdata=A5, held 3 cycles while rsp_ready=0.
REQ-034 MAC, ADC_OUT column 0 = 15'h7FFF, column 1 = 0, column 2 = 15'h00FF -> rsp_mac col0=+7, col1=-8, col2=0; rsp_valid at cycle 4.
REQ-035 MAC with row 0 pos, row 1 neg, row 2 both -> in MEVAL VDR_SEL[0]=1, VSS_SEL[1]=1, VRST_SEL[2]=1; complements exact.
REQ-036 op=11 -> err=1, no rsp_valid, next write accepted normally.
REQ-037 RST asserted in MEVAL -> outputs at reset values asynchronously, no rsp_valid after deassert.
